// File: rtl/mem_fifo_ctrl_pkg.sv
// Shared sizing for the memory-backed FIFO controller and its output skid buffer.
package mem_fifo_ctrl_pkg;

    localparam int ADDRESS_WIDTH_DEF = 4;
    localparam int DATA_WIDTH_DEF    = 16;

    // Skid occupancy is 0..2
    typedef logic [1:0] ob_cnt_t;

    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/mem_fifo_skid.sv
// Two-entry in-order output buffer; head entry drives the output stream.
module mem_fifo_skid
    import mem_fifo_ctrl_pkg::*;
#(
    parameter int DW = DATA_WIDTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output ob_cnt_t       cnt_o
);

    logic [DW-1:0] e0_q, e0_d, e1_q, e1_d;
    ob_cnt_t       cnt_q, cnt_d;

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        case ({push_i, pop_i})
            2'b10: begin
                if (cnt_q == 2'd0) e0_d = data_i;
                else               e1_d = data_i;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                e0_d  = e1_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                // Count is unchanged; the new word lands behind whatever stays
                if (cnt_q == 2'd2) begin
                    e0_d = e1_q;
                    e1_d = data_i;
                end else begin
                    e0_d = data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= '0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign data_o = e0_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/mem_fifo_ctrl.sv
// FIFO controller in front of a dual-port memory with a registered read port;
// owns the pointers, issues reads ahead and streams words through a skid buffer.
module mem_fifo_ctrl
    import mem_fifo_ctrl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [ADDRESS_WIDTH+1:0] level,
    output logic                     full,
    output logic                     empty,
    output logic                     mem_WR,
    output logic [ADDRESS_WIDTH-1:0] mem_wraddr,
    output logic [DATA_WIDTH-1:0]    mem_dataIn,
    output logic                     mem_RD,
    output logic [ADDRESS_WIDTH-1:0] mem_rdaddr,
    input  logic [DATA_WIDTH-1:0]    mem_dataOut
);

    localparam int DEPTH = fifo_depth(ADDRESS_WIDTH);
    localparam int PW    = ADDRESS_WIDTH + 1;
    localparam int LW    = ADDRESS_WIDTH + 2;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, mem_cnt;
    logic          rd_pending_q;
    ob_cnt_t       ob_cnt;
    logic          pop;
    logic [2:0]    ob_need;

    // Extra pointer MSB separates full from empty
    assign mem_cnt  = wr_ptr_q - rd_ptr_q;
    assign full     = (mem_cnt == PW'(DEPTH));
    assign in_ready = !full;

    assign pop     = out_valid & out_ready;
    // Skid slots already spoken for after this cycle's pop; a pop implies ob_cnt>=1
    assign ob_need = {1'b0, ob_cnt} + {2'b00, rd_pending_q} - {2'b00, pop};

    assign mem_WR     = !rst & in_valid & in_ready;
    assign mem_wraddr = wr_ptr_q[ADDRESS_WIDTH-1:0];
    assign mem_dataIn = in_data;
    assign mem_RD     = !rst & (mem_cnt != '0) & (ob_need < 3'd2);
    assign mem_rdaddr = rd_ptr_q[ADDRESS_WIDTH-1:0];

    assign wr_ptr_d = wr_ptr_q + {{ADDRESS_WIDTH{1'b0}}, mem_WR};
    assign rd_ptr_d = rd_ptr_q + {{ADDRESS_WIDTH{1'b0}}, mem_RD};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rd_pending_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_pending_q <= mem_RD;
        end
    end

    mem_fifo_skid #(.DW(DATA_WIDTH)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .push_i (rd_pending_q),
        .data_i (mem_dataOut),
        .pop_i  (pop),
        .data_o (out_data),
        .cnt_o  (ob_cnt)
    );

    assign out_valid = (ob_cnt != 2'd0);
    assign level     = LW'(mem_cnt) + LW'(rd_pending_q) + LW'(ob_cnt);
    assign empty     = (level == '0);

endmodule
